// File: rtl/sram_axi_bridge.sv
// Bridges the CPU fetch and load/store request ports onto one AXI-style master
// with a fixed-priority arbiter and a single transaction in flight.
module sram_axi_bridge #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, AR, R, W, B, RESP} state_t;

  state_t      state, state_next;
  logic        owner_data;
  logic        aw_done, w_done;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic        pick_data, any_req, aw_hs, w_hs;

  assign any_req   = inst_req || data_req;
  assign pick_data = data_req && (!inst_req || DATA_PRIORITY);
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_req) state_next = (pick_data && data_wen != 4'd0) ? W : AR;
      AR:   if (arvalid && arready) state_next = R;
      R:    if (rready && rvalid) state_next = RESP;
      W:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = B;
      B:    if (bready && bvalid) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are flops loaded from the next state, so no bus input
  // reaches a bus output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      owner_data <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wen_q      <= 4'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      arvalid <= (state_next == AR);
      rready  <= (state_next == R);
      bready  <= (state_next == B);
      inst_ok <= (state_next == RESP) && !owner_data;
      data_ok <= (state_next == RESP) && owner_data;

      if (state == IDLE && any_req) begin
        owner_data <= pick_data;
        addr_q     <= pick_data ? data_addr : inst_addr;
        if (pick_data) begin
          wdata_q <= data_wdata;
          wen_q   <= data_wen;
        end
      end

      // Address and data channels of a store complete independently.
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        awvalid <= (state_next == W);
        wvalid  <= (state_next == W);
      end else begin
        if (aw_hs) begin
          aw_done <= 1'b1;
          awvalid <= 1'b0;
        end
        if (w_hs) begin
          w_done <= 1'b1;
          wvalid <= 1'b0;
        end
      end

      if (state == R && rready && rvalid) begin
        if (owner_data) data_rdata <= rdata;
        else            inst_rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a configurable-latency slave, a
// transaction-level expectation queue checked every cycle, and literal timing pins.
module tb_sram_axi_bridge;

  localparam bit PRIO = 1'b1;

  logic        clk, rst;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = 32'd0, data_addr = 32'd0, data_wdata = 32'd0;
  logic [3:0]  data_wen = 4'd0;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_ok, data_ok;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = 32'd0;

  sram_axi_bridge #(.DATA_PRIORITY(PRIO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] hold_i = 32'd0, hold_d = 32'd0;
  bit          prev_ok = 1'b0;
  int          checks = 0, failures = 0;
  int          n_phase;
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          arv_cyc, rr_cyc, aw_cyc, w_cyc, br_cyc, other_ok_cyc;
  logic [31:0] araddr_c1, awaddr_c1;
  logic [3:0]  wstrb_c1;

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    case (a)
      32'h1FC0_0000: return 32'h3C08_BFAF;
      32'h0000_2000: return 32'h1234_5678;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Slave: each ready/valid rises after its channel has waited the set number of cycles.
  always @(negedge clk) begin
    if (rst) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rdata = 32'd0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      arready = arvalid && (ar_cnt >= ar_delay);
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      rvalid  = rready && (r_cnt >= r_delay);
      rdata   = rvalid ? slave_read(araddr) : 32'hBAD0_0BAD;
      r_cnt   = rready ? r_cnt + 1 : 0;
      awready = awvalid && (aw_cnt >= aw_delay);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt >= w_delay);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      bvalid  = bready && (b_cnt >= b_delay);
      b_cnt   = bready ? b_cnt + 1 : 0;
    end
  end

  // Per-cycle comparison of the bus and CPU ports against the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_i = 32'd0;
      hold_d = 32'd0;
      prev_ok = 1'b0;
      checkOutput("rst_ctrl", {25'd0, arvalid, rready, awvalid, wvalid, bready, inst_ok, data_ok}, 32'd0);
      checkOutput("rst_addr", araddr | awaddr, 32'd0);
      checkOutput("rst_wdata", {wdata[31:4], wdata[3:0] | wstrb}, 32'd0);
      checkOutput("rst_rdata", inst_rdata | data_rdata, 32'd0);
    end else begin
      n_phase = int'(arvalid) + int'(awvalid | wvalid) + int'(rready) + int'(bready);
      if (n_phase != 0) begin
        checkOutput("one_phase", 32'(n_phase <= 1), 32'd1);
        checkOutput("bus_busy_expected", 32'(exp_q.size() != 0), 32'd1);
      end
      if (exp_q.size() != 0) begin
        if (arvalid) begin
          checkOutput("araddr", araddr, exp_q[0].addr);
          checkOutput("ar_for_read", 32'(exp_q[0].is_write), 32'd0);
        end
        if (awvalid) begin
          checkOutput("awaddr", awaddr, exp_q[0].addr);
          checkOutput("aw_for_write", 32'(exp_q[0].is_write), 32'd1);
        end
        if (wvalid) begin
          checkOutput("wdata", wdata, exp_q[0].wdata);
          checkOutput("wstrb", 32'(wstrb), 32'(exp_q[0].wen));
        end
      end
      if (inst_ok || data_ok) begin
        checkOutput("single_ok", 32'(inst_ok && data_ok), 32'd0);
        checkOutput("ok_one_cycle", 32'(prev_ok), 32'd0);
        checkOutput("ok_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          checkOutput("ok_owner", 32'(data_ok), 32'(exp_q[0].is_data));
          if (!exp_q[0].is_write) begin
            if (exp_q[0].is_data) hold_d = exp_q[0].rdata;
            else                  hold_i = exp_q[0].rdata;
          end
          void'(exp_q.pop_front());
        end
      end
      prev_ok = inst_ok || data_ok;
      checkOutput("inst_rdata_hold", inst_rdata, hold_i);
      checkOutput("data_rdata_hold", data_rdata, hold_d);
    end
  end

  // One request on one port; returns cycles from the sampling cycle to its ok.
  task automatic applyStimulus(input bit is_data, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wd, output int lat);
    txn_t t;
    t.is_data  = is_data;
    t.is_write = is_data && (wen != 4'd0);
    t.addr     = addr;
    t.wdata    = wd;
    t.wen      = wen;
    t.rdata    = slave_read(addr);
    exp_q.push_back(t);
    if (is_data) begin
      data_req = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    lat = 0; arv_cyc = 0; rr_cyc = 0; aw_cyc = 0; w_cyc = 0; br_cyc = 0; other_ok_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      arv_cyc += int'(arvalid); rr_cyc += int'(rready);
      aw_cyc += int'(awvalid);  w_cyc += int'(wvalid); br_cyc += int'(bready);
      other_ok_cyc += int'(is_data ? inst_ok : data_ok);
      if (c == 1) begin
        araddr_c1 = araddr; awaddr_c1 = awaddr; wstrb_c1 = wstrb;
        // Latched fields must not follow the ports after sampling.
        if (is_data) begin
          data_addr = ~addr; data_wdata = ~wd; data_wen = ~wen;
        end else begin
          inst_addr = ~addr;
        end
      end
      if (is_data ? data_ok : inst_ok) begin
        lat = c;
        break;
      end
    end
    if (is_data) data_req = 1'b0;
    else         inst_req = 1'b0;
    checkOutput("completed_in_budget", 32'(lat != 0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, first_c, second_c;
    bit first_data, second_data, seen;
    txn_t ti, td;

    rst = 1'b1;
    #3;
    checkOutput("init_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    checkOutput("init_oks", {30'd0, inst_ok, data_ok}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] zero-wait fetch");
    applyStimulus(1'b0, 4'd0, 32'h1FC0_0000, 32'd0, lat);
    checkOutput("fetch_latency", 32'(lat), 32'd3);
    checkOutput("fetch_araddr_c1", araddr_c1, 32'h1FC0_0000);
    checkOutput("fetch_inst_rdata", inst_rdata, 32'h3C08_BFAF);
    checkOutput("fetch_no_data_ok", 32'(other_ok_cyc), 32'd0);

    $display("[TB] store with skewed handshakes");
    aw_delay = 0; w_delay = 2; b_delay = 1;
    applyStimulus(1'b1, 4'b0011, 32'h0000_1004, 32'hDEAD_BEEF, lat);
    checkOutput("store_latency", 32'(lat), 32'd6);
    checkOutput("store_wstrb_c1", 32'(wstrb_c1), 32'h3);
    checkOutput("store_awaddr_c1", awaddr_c1, 32'h0000_1004);
    checkOutput("store_aw_cycles", 32'(aw_cyc), 32'd1);
    checkOutput("store_w_cycles", 32'(w_cyc), 32'd3);
    checkOutput("store_b_cycles", 32'(br_cyc), 32'd2);
    checkOutput("store_no_ar", 32'(arv_cyc + rr_cyc), 32'd0);
    checkOutput("store_data_rdata", data_rdata, 32'd0);
    w_delay = 0; b_delay = 0;

    $display("[TB] zero-wait store");
    applyStimulus(1'b1, 4'b1111, 32'h0000_2004, 32'hCAFE_F00D, lat);
    checkOutput("store0_latency", 32'(lat), 32'd3);

    $display("[TB] fetch/load conflict");
    ti = '{is_data: 1'b0, is_write: 1'b0, addr: 32'h1FC0_0010, wdata: 32'd0, wen: 4'd0,
           rdata: slave_read(32'h1FC0_0010)};
    td = '{is_data: 1'b1, is_write: 1'b0, addr: 32'h0000_3000, wdata: 32'd0, wen: 4'd0,
           rdata: slave_read(32'h0000_3000)};
    if (PRIO) begin exp_q.push_back(td); exp_q.push_back(ti); end
    else      begin exp_q.push_back(ti); exp_q.push_back(td); end
    inst_req = 1'b1; inst_addr = ti.addr;
    data_req = 1'b1; data_addr = td.addr; data_wen = 4'd0;
    first_c = 0; second_c = 0; first_data = 1'b0; second_data = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (inst_ok || data_ok) begin
        if (first_c == 0) begin
          first_c = c; first_data = data_ok;
          if (data_ok) data_req = 1'b0;
          else         inst_req = 1'b0;
        end else begin
          second_c = c; second_data = data_ok;
          break;
        end
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    checkOutput("conflict_first_owner", 32'(first_data), 32'(PRIO));
    checkOutput("conflict_first_latency", 32'(first_c), 32'd3);
    checkOutput("conflict_gap", 32'(second_c - first_c), 32'd4);
    checkOutput("conflict_second_owner", 32'(second_data), 32'(!PRIO));
    checkOutput("conflict_load_rdata", data_rdata, 32'h3000_CFFF);
    @(posedge clk); #1;

    $display("[TB] slave stalls");
    ar_delay = 5; r_delay = 3;
    applyStimulus(1'b0, 4'd0, 32'h1FC0_0020, 32'd0, lat);
    checkOutput("stall_latency", 32'(lat), 32'd11);
    checkOutput("stall_ar_cycles", 32'(arv_cyc), 32'd6);
    checkOutput("stall_r_cycles", 32'(rr_cyc), 32'd4);
    ar_delay = 0; r_delay = 0;

    $display("[TB] data hold across fetches");
    applyStimulus(1'b1, 4'd0, 32'h0000_2000, 32'd0, lat);
    checkOutput("load_rdata", data_rdata, 32'h1234_5678);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 32'h1FC0_0000 + 32'(4 * i), 32'd0, lat);
    checkOutput("hold_data_rdata", data_rdata, 32'h1234_5678);
    checkOutput("hold_inst_rdata", inst_rdata, 32'h0008_FFF7);

    $display("[TB] reset mid-read");
    r_delay = 10;
    ti = '{is_data: 1'b0, is_write: 1'b0, addr: 32'h1FC0_0030, wdata: 32'd0, wen: 4'd0,
           rdata: slave_read(32'h1FC0_0030)};
    exp_q.push_back(ti);
    inst_req = 1'b1; inst_addr = ti.addr;
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rready) begin seen = 1'b1; break; end
    end
    checkOutput("midrst_reached_r", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ctrl", {25'd0, arvalid, rready, awvalid, wvalid, bready, inst_ok, data_ok}, 32'd0);
    checkOutput("midrst_inst_rdata", inst_rdata, 32'd0);
    inst_req = 1'b0;
    r_delay = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd0, 32'h1FC0_0040, 32'd0, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd3);
    checkOutput("post_rst_inst_rdata", inst_rdata, 32'h0040_FFBF);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the CPU's two request/acknowledge memory ports (instruction fetch, data load/store) into a single AXI-style master with one transaction outstanding at a time. It sits directly downstream of the CPU top, after MMU address translation, and takes the physical addresses, byte write enables and write data that the core drives. Its fixed arbiter serialises instruction and data traffic onto one bus port.

## Interface
- DATA_PRIORITY, default 1: 1 = data request wins a simultaneous IDLE-cycle conflict; 0 = instruction wins.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held high until inst_ok.
- inst_addr  in  32  physical fetch address, word aligned.
- inst_rdata  out  32  fetched word; valid with inst_ok, held until next inst completion.
- inst_ok  out  1  one-cycle completion pulse.
- data_req  in  1  load/store request; held high until data_ok.
- data_wen  in  4  byte write enables; 0 = load, nonzero = store.
- data_addr  in  32  physical data address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load result; valid with data_ok, held until next data read completion.
- data_ok  out  1  one-cycle completion pulse.
- araddr  out  32  read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address accepted.
- rdata  in  32  read data.
- rvalid  in  1  read data valid.
- rready  out  1  read data accept.
- awaddr  out  32  write address.
- awvalid  out  1  write address valid.
- awready  in  1  write address accepted.
- wdata  out  32  write data.
- wstrb  out  4  write byte strobes.
- wvalid  out  1  write data valid.
- wready  in  1  write data accepted.
- bvalid  in  1  write response valid.
- bready  out  1  write response accept.
- Bus is single-beat, 4-byte, no IDs. Response codes are not present and not checked.

## Operation
- States: IDLE, AR, R, W, B, RESP.
- IDLE: the arbiter selects an owner from inst_req and data_req. On a conflict, DATA_PRIORITY decides. The bridge latches the address, plus wdata and wen for a data request, and records the owner.
  - Store (data_wen != 0): go to W.
  - Load or fetch: go to AR.
  - No request: stay in IDLE.
- AR: arvalid=1 with the latched address. On arready, go to R.
- R: rready=1. On rvalid, capture rdata into the owner's rdata register and go to RESP.
- W: awvalid and wvalid are both asserted on entry. Each one drops independently after its own handshake, tracked by aw_done and w_done flags. A handshake in the same cycle as the other is allowed. When both are done, go to B.
- B: bready=1. On bvalid, go to RESP.
- RESP: assert the owner's ok for exactly one cycle, then go to IDLE.
- The requester deasserts req, or presents a new request, in the cycle after ok. The bridge samples requests only in IDLE.
- Request inputs that change outside IDLE are ignored, because all transaction fields are latched.
- The bridge passes addresses through unchanged. It does not translate or check alignment.

## Timing
- Reset, effective immediately and asynchronously:
  - state=IDLE.
  - All valid and ready outputs, inst_ok and data_ok are 0.
  - inst_rdata and data_rdata are 0.
  - araddr, awaddr, wdata and wstrb are 0.
- Reset mid-transaction abandons the transaction and drops every bus output in the same cycle. The pending ok is never issued.
- Zero-wait slave: request sampled in IDLE at cycle 0; handshake in cycle 1; rvalid or bvalid in cycle 2; ok in cycle 3. Minimum latency is 3 cycles from the request-sample edge to ok.
- Back-to-back requests: the next request is sampled in the IDLE cycle after RESP, so sustained throughput is one transaction per 4 cycles.
- The bridge never has more than one of arvalid, awvalid/wvalid or rready/bready phases active at once.
- A read and a write are never outstanding together.
- Bus outputs are registered. No combinational path runs from any bus input to any bus output.

## Test plan
- Fetch with zero-wait slave: inst_req, inst_addr=0x1FC00000, rdata=0x3C08BFAF → araddr=0x1FC00000 in cycle 1, then inst_ok with inst_rdata=0x3C08BFAF in cycle 3. data_ok stays 0.
- Store with skewed handshakes: data_wen=4'b0011, addr=0x00001004, wdata=0xDEADBEEF; awready in cycle 1, wready in cycle 3, bvalid in cycle 5 → wstrb=0011, wvalid held until cycle 3, awvalid dropped after cycle 1, data_ok in cycle 6.
- Conflict: inst_req and data_req (load) in the same cycle with DATA_PRIORITY=1 → data read is issued first. The fetch follows in the IDLE cycle after data_ok. With DATA_PRIORITY=0, the order reverses.
- Slave stalls: arready held 0 for 5 cycles → arvalid and araddr are stable throughout. rvalid delayed 3 cycles → rready held. ok still pulses for exactly one cycle.
- Reset mid-read: rst asserted while in R → rready, arvalid and the ok outputs go to 0 immediately. After release, the bridge starts in IDLE and a new request completes normally.
- Data hold: a load completes with 0x12345678, then 3 fetches complete → data_rdata stays 0x12345678.
